// File: rtl/text_wr_sched_if.sv
// Requester/text-RAM bundle for text_wr_sched: character push, clear/window control,
// RAM write port and status flags.
interface text_wr_sched_if;
  logic        i_char_valid;
  logic [7:0]  i_char;
  logic        o_char_ready;
  logic        i_clear;
  logic        i_wr_window;
  logic        o_we;
  logic [11:0] o_addr;
  logic [7:0]  o_din;
  logic        o_busy;
  logic        o_overflow;

  modport master (
    output i_char_valid, i_char, i_clear, i_wr_window,
    input  o_char_ready, o_we, o_addr, o_din, o_busy, o_overflow
  );

  modport slave (
    input  i_char_valid, i_char, i_clear, i_wr_window,
    output o_char_ready, o_we, o_addr, o_din, o_busy, o_overflow
  );
endinterface

// File: rtl/text_wr_sched.sv
// Text RAM write scheduler: buffers characters in a small FIFO and writes them to
// successive cells only inside the display write window; also runs full-screen clears.
module text_wr_sched #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LAST_ADDR  = 2399,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input logic             i_clk,
  input logic             i_rst,
  text_wr_sched_if.slave  bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [11:0] LAST = 12'(LAST_ADDR);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   cursor_q, cursor_d;
  logic [11:0]   clr_addr_q, clr_addr_d;
  logic          we_q, we_d;
  logic [11:0]   addr_q, addr_d;
  logic [7:0]    din_q, din_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [DEPTH];

  logic char_ready;
  logic push;
  logic pop;

  assign char_ready = (count_q != CW'(DEPTH));
  assign push       = bus.i_char_valid && char_ready;

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    clr_addr_d = clr_addr_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    ovf_d      = ovf_q;
    pop        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_clear) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          ovf_d      = 1'b0;
        end else if (bus.i_wr_window && (count_q != '0)) begin
          pop      = 1'b1;
          we_d     = 1'b1;
          addr_d   = cursor_q;
          din_d    = mem_q[rd_ptr_q];
          cursor_d = (cursor_q == LAST) ? '0 : cursor_q + 12'd1;
        end
      end
      ST_CLEAR: begin
        if (bus.i_wr_window) begin
          we_d   = 1'b1;
          addr_d = clr_addr_q;
          din_d  = CLEAR_CHAR;
          if (clr_addr_q == LAST) begin
            state_d    = ST_IDLE;
            cursor_d   = '0;
            clr_addr_d = '0;
          end else begin
            clr_addr_d = clr_addr_q + 12'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A drop in the same edge as a clear request still gets recorded.
    if (bus.i_char_valid && !char_ready) ovf_d = 1'b1;

    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cursor_q   <= '0;
      clr_addr_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      clr_addr_q <= clr_addr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_char;
  end

  assign bus.o_char_ready = char_ready;
  assign bus.o_we         = we_q;
  assign bus.o_addr       = addr_q;
  assign bus.o_din        = din_q;
  assign bus.o_busy       = (state_q == ST_CLEAR);
  assign bus.o_overflow   = ovf_q;
endmodule

// File: tb/tb_text_wr_sched.sv
// Self-checking bench for text_wr_sched: directed scenarios plus random traffic,
// compared against a queue-based model of the write scheduler.
module tb_text_wr_sched;
  localparam int DEPTH = 4;
  localparam int LAST  = 2399;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  text_wr_sched_if bus_if ();

  text_wr_sched #(.DEPTH(DEPTH), .LAST_ADDR(LAST), .CLEAR_CHAR(8'h20)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_q[$];
  int          m_cursor, m_clr;
  bit          m_clearing, m_ovf;
  bit          e_we;
  logic [11:0] e_addr;
  logic [7:0]  e_din;

  logic [23:0] dut_vec;
  assign dut_vec = {bus_if.o_we, bus_if.o_addr, bus_if.o_din,
                    bus_if.o_busy, bus_if.o_overflow, bus_if.o_char_ready};

  function automatic logic [23:0] exp_vec();
    return {e_we, e_addr, e_din, m_clearing, m_ovf, (m_q.size() != DEPTH)};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cursor = 0; m_clr = 0; m_clearing = 0; m_ovf = 0;
    e_we = 0; e_addr = '0; e_din = '0;
  endtask

  task automatic drive(input bit v, input logic [7:0] c, input bit clr, input bit win);
    bus_if.i_char_valid = v;
    bus_if.i_char       = c;
    bus_if.i_clear      = clr;
    bus_if.i_wr_window  = win;
  endtask

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    bit ready, v, clr, win;
    logic [7:0] c;
    @(posedge clk);
    v = bus_if.i_char_valid; c = bus_if.i_char; clr = bus_if.i_clear; win = bus_if.i_wr_window;
    if (rst) begin
      model_reset();
    end else begin
      ready = (m_q.size() != DEPTH);
      e_we  = 0;
      if (m_clearing) begin
        if (win) begin
          e_we = 1; e_addr = 12'(m_clr); e_din = 8'h20;
          if (m_clr == LAST) begin m_clearing = 0; m_cursor = 0; end
          m_clr++;
        end
      end else if (clr) begin
        m_clearing = 1; m_clr = 0; m_ovf = 0;
      end else if (win && m_q.size() > 0) begin
        e_we = 1; e_addr = 12'(m_cursor); e_din = m_q.pop_front();
        m_cursor = (m_cursor + 1) % (LAST + 1);
      end
      if (v) begin
        if (ready) m_q.push_back(c);
        else m_ovf = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 8'h00, 0, 0);
    model_reset();
    tick(); tick();
    checks++;
    if (dut_vec !== 24'h000001) begin
      errors++; $display("FAIL reset_state: got %h expected %h", dut_vec, 24'h000001);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_release: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_basic();
    int pulses = 0;
    drive(1, 8'h41, 0, 0); tick();
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL basic_push0: got %h expected %h", dut_vec, exp_vec()); end
    drive(1, 8'h42, 0, 0); tick();
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL basic_push1: got %h expected %h", dut_vec, exp_vec()); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h00, 0, 1); tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL basic_write cyc %0d: got %h expected %h", i, dut_vec, exp_vec()); end
      if (bus_if.o_we) pulses++;
    end
    checks++;
    if (pulses !== 2) begin errors++; $display("FAIL basic_pulse_count: got %0d expected 2", pulses); end
  endtask

  task automatic test_overflow();
    int writes = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'h60 + 8'(i), 0, 0); tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL ovf_push %0d: got %h expected %h", i, dut_vec, exp_vec()); end
      if (i == 3) begin
        checks++;
        if (bus_if.o_char_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready_full: got %b expected 0", bus_if.o_char_ready); end
      end
    end
    checks++;
    if (bus_if.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", bus_if.o_overflow); end
    for (int i = 0; i < 6; i++) begin
      drive(0, 8'h00, 0, 1); tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL ovf_drain cyc %0d: got %h expected %h", i, dut_vec, exp_vec()); end
      if (bus_if.o_we) writes++;
    end
    checks++;
    if (writes !== 4) begin errors++; $display("FAIL ovf_drain_count: got %0d expected 4", writes); end
  endtask

  task automatic test_clear();
    int n = 0;
    drive(0, 8'h00, 1, 0); tick();
    checks++;
    if ({bus_if.o_busy, bus_if.o_overflow, bus_if.o_we} !== 3'b100) begin
      errors++; $display("FAIL clear_start busy/ovf/we: got %b expected 100", {bus_if.o_busy, bus_if.o_overflow, bus_if.o_we});
    end
    for (int cyc = 0; cyc < 6000 && n < LAST + 1; cyc++) begin
      drive(0, 8'h00, 0, cyc[0]); tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL clear_cycle %0d: got %h expected %h", cyc, dut_vec, exp_vec()); end
      if (bus_if.o_we) begin
        checks++;
        if ({bus_if.o_addr, bus_if.o_din} !== {12'(n), 8'h20}) begin
          errors++; $display("FAIL clear_write %0d: got addr %0d din %h expected addr %0d din 20", n, bus_if.o_addr, bus_if.o_din, n);
        end
        n++;
      end
    end
    checks++;
    if (n !== LAST + 1) begin errors++; $display("FAIL clear_write_count: got %0d expected %0d", n, LAST + 1); end
    checks++;
    if (bus_if.o_busy !== 1'b0) begin errors++; $display("FAIL clear_done_busy: got %b expected 0", bus_if.o_busy); end
    drive(1, 8'h7E, 0, 0); tick();
    drive(0, 8'h00, 0, 1); tick();
    checks++;
    if ({bus_if.o_we, bus_if.o_addr, bus_if.o_din} !== {1'b1, 12'd0, 8'h7E}) begin
      errors++; $display("FAIL clear_next_char: got we %b addr %0d din %h expected we 1 addr 0 din 7e", bus_if.o_we, bus_if.o_addr, bus_if.o_din);
    end
  endtask

  task automatic test_clear_ignore();
    int n = 0;
    drive(0, 8'h00, 1, 1); tick();
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL ign_start: got %h expected %h", dut_vec, exp_vec()); end
    for (int k = 1; k < 3000 && n < LAST + 1; k++) begin
      drive(k == 1, 8'h5A, k == 3, 1); tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL ign_cycle %0d: got %h expected %h", k, dut_vec, exp_vec()); end
      if (bus_if.o_we) begin
        checks++;
        if ({bus_if.o_addr, bus_if.o_din} !== {12'(n), 8'h20}) begin
          errors++; $display("FAIL ign_write %0d: got addr %0d din %h expected addr %0d din 20", n, bus_if.o_addr, bus_if.o_din, n);
        end
        n++;
      end
    end
    checks++;
    if (n !== LAST + 1) begin errors++; $display("FAIL ign_write_count: got %0d expected %0d", n, LAST + 1); end
    drive(0, 8'h00, 0, 1); tick();
    checks++;
    if ({bus_if.o_we, bus_if.o_addr, bus_if.o_din, bus_if.o_busy} !== {1'b1, 12'd0, 8'h5A, 1'b0}) begin
      errors++; $display("FAIL ign_held_char: got we %b addr %0d din %h busy %b expected 1 0 5a 0", bus_if.o_we, bus_if.o_addr, bus_if.o_din, bus_if.o_busy);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    rst = 1'b1; drive(0, 8'h00, 0, 0); tick(); rst = 1'b0;
    for (int k = 0; k < 2500; k++) begin
      drive(k < LAST + 2, 8'($urandom), 0, 1); tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL wrap_cycle %0d: got %h expected %h", k, dut_vec, exp_vec()); end
      if (bus_if.o_we) begin
        if (n == LAST) begin
          checks++;
          if (bus_if.o_addr !== 12'(LAST)) begin errors++; $display("FAIL wrap_last_addr: got %0d expected %0d", bus_if.o_addr, LAST); end
        end
        if (n == LAST + 1) begin
          checks++;
          if (bus_if.o_addr !== 12'd0) begin errors++; $display("FAIL wrap_to_zero: got %0d expected 0", bus_if.o_addr); end
        end
        n++;
      end
    end
    checks++;
    if (n !== LAST + 2) begin errors++; $display("FAIL wrap_write_count: got %0d expected %0d", n, LAST + 2); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 1) == 1, 8'($urandom), 0, $urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_cycle %0d: got %h expected %h", k, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_async_reset();
    bit hit = 0;
    drive(0, 8'h00, 1, 1); tick();
    drive(1, 8'h31, 0, 1); tick();
    drive(1, 8'h32, 0, 1); tick();
    for (int k = 0; k < 300 && !hit; k++) begin
      drive(0, 8'h00, 0, 1); tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL areset_clear %0d: got %h expected %h", k, dut_vec, exp_vec()); end
      if (bus_if.o_we && bus_if.o_addr == 12'd100) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL areset_reach_100: got no write to addr 100 expected one"); end
    #1 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 24'h000001) begin errors++; $display("FAIL areset_immediate: got %h expected %h", dut_vec, 24'h000001); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(0, 8'h00, 0, 1); tick();
      checks++;
      if (dut_vec !== exp_vec() || bus_if.o_we !== 1'b0) begin
        errors++; $display("FAIL areset_quiet %0d: got %h expected %h", k, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_clear();
    test_clear_ignore();
    test_wrap();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
